// File: rtl/program_loader_ctrl_if.sv
// program_loader_ctrl_if
// Groups the loader's byte-stream handshake and its instruction-memory byte
// write port into one bundle.
// Signals:
//   rx_valid, rx_data   byte offered by the host/UART receiver
//   rx_ready            loader accepts the byte on this edge
//   pmem_write_*        byte write port into program_memory
// Modports:
//   master  the loader side: consumes the stream and drives the memory port
//   slave   the host/memory side: drives the stream and observes the writes
interface program_loader_ctrl_if #(
  parameter int XLEN_WIDTH = 32
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic [XLEN_WIDTH-1:0] pmem_write_address;
  logic                  pmem_write_enable;
  logic [7:0]            pmem_write_data;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, pmem_write_address, pmem_write_enable, pmem_write_data
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, pmem_write_address, pmem_write_enable, pmem_write_data
  );
endinterface

// File: rtl/program_loader_ctrl.sv
// program_loader_ctrl
// Boot-time sequencer for the byte-writable instruction memory. Takes a
// length-prefixed image (4-byte little-endian LEN, then LEN data bytes) off a
// valid/ready byte stream, writes the data sequentially from address 0 and
// keeps the core stalled until the image has landed.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing
// two's-complement checksum byte after the data; without it the load
// completes straight after the last data byte.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   start          one-cycle restart pulse, honoured only in DONE/ERROR
//   bus            stream handshake + memory byte write port (master modport)
//   cpu_hold       core stall, high in every state except DONE
//   load_done      image loaded (and verified when checksum is enabled)
//   load_error     image rejected; sticky until start or reset
//   bytes_written  data bytes accepted in the current load
//
// state | meaning
// HDR   | collecting the 4 LEN bytes
// DATA  | writing LEN data bytes to memory
// CHK   | waiting for the checksum byte (checksum build only)
// FLUSH | one idle cycle so the last write strobe completes
// DONE  | image in place, core released
// ERROR | image rejected, core held
module program_loader_ctrl #(
  parameter int MEM_BYTES  = 1024,
  parameter int XLEN_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  program_loader_ctrl_if.master bus,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [31:0]           bytes_written
);
  localparam int PTR_W = $clog2(MEM_BYTES) + 1;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_FLUSH,
    S_DONE,
    S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       hdr_cnt_q, hdr_cnt_d;
  logic [31:0]      len_q, len_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [31:0]      bw_q, bw_d;
  logic             rx_ready_q, rx_ready_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  logic        accept;
  logic [31:0] len_full;
  logic        last_byte;

  // rx_ready is a register, so the handshake has no rx_valid->rx_ready path.
  assign accept    = bus.rx_valid && rx_ready_q;
  // LEN as it will be once the current (4th) header byte lands in [31:24].
  assign len_full  = {bus.rx_data, len_q[23:0]};
  assign last_byte = (32'(ptr_q) + 32'd1) == len_q;

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    bw_d      = bw_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    case (state_q)
      S_HDR: begin
        if (accept) begin
          len_d[{hdr_cnt_q, 3'b000} +: 8] = bus.rx_data;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            if (len_full == 32'd0 || len_full > 32'(MEM_BYTES)) begin
              state_d = S_ERROR;
            end else begin
              state_d = S_DATA;
              ptr_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              sum_d   = 8'd0;
`endif
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = bus.rx_data;
          ptr_d   = ptr_q + PTR_W'(1);
          bw_d    = bw_q + 32'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + bus.rx_data;
          if (last_byte) state_d = S_CHK;
`else
          if (last_byte) state_d = S_FLUSH;
`endif
        end
      end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK: begin
        // The check byte is consumed but never written to memory.
        if (accept) begin
          if (8'(sum_q + bus.rx_data) == 8'd0) state_d = S_FLUSH;
          else                                 state_d = S_ERROR;
        end
      end
`endif

      S_FLUSH: state_d = S_DONE;

      S_DONE, S_ERROR: begin
        if (start) begin
          state_d   = S_HDR;
          hdr_cnt_d = 2'd0;
          len_d     = 32'd0;
          bw_d      = 32'd0;
        end
      end

      default: state_d = S_HDR;
    endcase

    // Status outputs are registered from the next state.
    rx_ready_d = (state_d == S_HDR) || (state_d == S_DATA)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                 || (state_d == S_CHK)
`endif
                 ;
    hold_d = (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_HDR;
      hdr_cnt_q  <= 2'd0;
      len_q      <= 32'd0;
      ptr_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= 8'd0;
      we_q       <= 1'b0;
      bw_q       <= 32'd0;
      rx_ready_q <= 1'b1;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      len_q      <= len_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      bw_q       <= bw_d;
      rx_ready_q <= rx_ready_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign bus.rx_ready           = rx_ready_q;
  assign bus.pmem_write_enable  = we_q;
  assign bus.pmem_write_address = XLEN_WIDTH'(addr_q);
  assign bus.pmem_write_data    = wdata_q;
  assign cpu_hold               = hold_q;
  assign load_done              = done_q;
  assign load_error             = err_q;
  assign bytes_written          = bw_q;
endmodule

// File: tb/tb_program_loader_ctrl.sv
// Bench for program_loader_ctrl. Stimulus pushes every expected memory write
// ({address, data}) into a queue; a monitor on the falling edge pops and
// compares whenever the write strobe is high. Status outputs are compared
// directly by the stimulus process at known points.
module tb_program_loader_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [31:0] bytes_written;

  program_loader_ctrl_if #(.XLEN_WIDTH(32)) bus_if ();

  program_loader_ctrl #(.MEM_BYTES(1024), .XLEN_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .bus           (bus_if),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_error    (load_error),
    .bytes_written (bytes_written)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [39:0] exp_q[$];
  int          n_strobes = 0;
  int          last_addr = -1;
  logic [7:0]  img[0:1023];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  tb_sum;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input string detail);
    n_total++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus_if.pmem_write_enable === 1'b1) begin
      logic [39:0] e;
      n_strobes++;
      last_addr = int'(bus_if.pmem_write_address);
      if (exp_q.size() == 0) begin
        fail("spurious_write", $sformatf("strobe at addr 0x%0h data 0x%0h, required no write",
             bus_if.pmem_write_address, bus_if.pmem_write_data));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", bus_if.pmem_write_address, e[39:8]);
        check("wr_data", 32'(bus_if.pmem_write_data), 32'(e[7:0]));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) begin
      bus_if.rx_valid = 1'b0;
      @(negedge clk);
    end
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = b;
    waited = 0;
    while (bus_if.rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (bus_if.rx_ready !== 1'b1) fail("rx_ready_timeout", "rx_ready stayed 0, required 1");
    @(negedge clk);
  endtask

  task automatic send_header(input logic [31:0] len, input int gap);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], gap);
  endtask

  task automatic send_payload(input int len, input int gap);
    send_header(32'(len), gap);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    tb_sum = 8'd0;
`endif
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({32'(i), img[i]});
      send_byte(img[i], gap);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      tb_sum = tb_sum + img[i];
`endif
    end
  endtask

  task automatic send_image(input int len, input int gap);
    send_payload(len, gap);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'd0 - tb_sum, gap);
`endif
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic [31:0] len);
    // Last accepted byte was at the previous rising edge: FLUSH now, DONE next.
    check({tag, "_flush_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_flush_done"}, 32'(load_done), 32'd0);
    @(negedge clk);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd1);
    check({tag, "_ready"}, 32'(bus_if.rx_ready), 32'd0);
    check({tag, "_bytes"}, bytes_written, len);
  endtask

  task automatic expect_error(input string tag);
    check({tag, "_err"}, 32'(load_error), 32'd1);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_ready"}, 32'(bus_if.rx_ready), 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int s0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values
    check("rst_ready", 32'(bus_if.rx_ready), 32'd1);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_error), 32'd0);
    check("rst_bytes", bytes_written, 32'd0);
    check("rst_we", 32'(bus_if.pmem_write_enable), 32'd0);
    check("rst_addr", bus_if.pmem_write_address, 32'd0);
    check("rst_wdata", 32'(bus_if.pmem_write_data), 32'd0);

    // 4-byte image 13 00 00 00 (checksum ED), valid held high
    img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
    s0 = n_strobes;
    send_image(4, 0);
    expect_done("img4", 32'd4);
    check("img4_strobes", 32'(n_strobes - s0), 32'd4);

    // start together with rx_valid: byte must not be taken
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus_if.rx_valid = 1'b0;
    check("restart_ready", 32'(bus_if.rx_ready), 32'd1);
    check("restart_hold", 32'(cpu_hold), 32'd1);
    check("restart_done", 32'(load_done), 32'd0);
    check("restart_bytes", bytes_written, 32'd0);

    // LEN = 1025 > MEM_BYTES
    send_header(32'd1025, 0);
    bus_if.rx_valid = 1'b0;
    expect_error("len1025");
    check("len1025_bytes", bytes_written, 32'd0);
    pulse_start();
    check("len1025_restart_err", 32'(load_error), 32'd0);

    // LEN = 0
    send_header(32'd0, 0);
    bus_if.rx_valid = 1'b0;
    expect_error("len0");
    pulse_start();
    check("len0_restart_ready", 32'(bus_if.rx_ready), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Wrong checksum EE after 13 00 00 00
    img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
    send_payload(4, 0);
    send_byte(8'hEE, 0);
    bus_if.rx_valid = 1'b0;
    expect_error("badchk");
    check("badchk_bytes", bytes_written, 32'd4);
    pulse_start();
    check("badchk_restart_ready", 32'(bus_if.rx_ready), 32'd1);
    check("badchk_restart_err", 32'(load_error), 32'd0);
`else
    // 02 00 00 00 AA BB, then a further byte offered that must not be consumed
    img[0] = 8'hAA; img[1] = 8'hBB;
    send_payload(2, 0);
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = 8'hCC;
    check("two_flush_ready", 32'(bus_if.rx_ready), 32'd0);
    expect_done("two", 32'd2);
    @(negedge clk);
    check("two_still_ready", 32'(bus_if.rx_ready), 32'd0);
    check("two_still_bytes", bytes_written, 32'd2);
    bus_if.rx_valid = 1'b0;
    pulse_start();
`endif

    // Full 1024-byte image with rx_valid toggling
    for (int i = 0; i < 1024; i++) img[i] = 8'((i * 7 + 3) & 255);
    s0 = n_strobes;
    send_image(1024, 1);
    expect_done("full", 32'd1024);
    check("full_strobes", 32'(n_strobes - s0), 32'd1024);
    check("full_last_addr", 32'(last_addr), 32'h3FF);

    // Reset after the 2nd data byte, with a 3rd byte on the wire at the reset edge
    pulse_start();
    img[0] = 8'h21; img[1] = 8'h42; img[2] = 8'h63; img[3] = 8'h84;
    send_header(32'd4, 0);
    exp_q.push_back({32'd0, img[0]});
    send_byte(img[0], 0);
    exp_q.push_back({32'd1, img[1]});
    send_byte(img[1], 0);
    bus_if.rx_data = img[2];
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_if.rx_valid = 1'b0;
    check("rstmid_we", 32'(bus_if.pmem_write_enable), 32'd0);
    check("rstmid_ready", 32'(bus_if.rx_ready), 32'd1);
    check("rstmid_bytes", bytes_written, 32'd0);
    check("rstmid_hold", 32'(cpu_hold), 32'd1);
    send_image(4, 0);
    expect_done("reload", 32'd4);

    repeat (3) @(negedge clk);
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1);
  end
endmodule
